// File: rtl/pipe_stall_ctrl_if.sv
// Stall-control bundle between the pipeline front end (master) and the
// central stall scheduler (slave).
interface pipe_stall_ctrl_if #(
    parameter int unsigned STALL_W = 6
);
    logic               stallreq_from_if;
    logic               stallreq_from_id;
    logic               mc_start;
    logic               flush;
    logic               clr_cnt;
    logic [STALL_W-1:0] stall;
    logic               mc_busy;
    logic               mc_done;
    logic               mc_err;
    logic [31:0]        stall_cycles;

    modport master (
        output stallreq_from_if, stallreq_from_id, mc_start, flush, clr_cnt,
        input  stall, mc_busy, mc_done, mc_err, stall_cycles
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, mc_start, flush, clr_cnt,
        output stall, mc_busy, mc_done, mc_err, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler: merges IF/ID/multi-cycle stall requests onto the
// stall bus, sequences multi-cycle unit occupancy and counts stalled cycles.
module pipe_stall_ctrl #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned MC_LAT  = 33
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [5:0]  LP_CNT_INIT = 6'(MC_LAT - 2);
    localparam logic [3:0]  LP_ENC_IF   = 4'b0011;
    localparam logic [3:0]  LP_ENC_ID   = 4'b0111;
    localparam logic [3:0]  LP_ENC_MC   = 4'b1111;
    localparam logic [31:0] LP_CNT_MAX  = '1;

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic         r_mc_err;
    logic [31:0]  r_stall_cycles;

    logic               w_busy;
    logic               w_mc_accept;
    logic               w_mc_stall;
    logic               w_mc_last;
    logic [3:0]         w_req_lo;
    logic [STALL_W-1:0] w_stall;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_mc_accept = !w_busy && bus.mc_start && !bus.flush;
    assign w_mc_stall  = w_mc_accept || w_busy;
    // A flush in the final occupancy cycle aborts the op, so no done pulse.
    assign w_mc_last   = w_busy && (r_cnt == 6'd0) && !bus.flush;

    always_comb begin
        w_req_lo = ({4{bus.stallreq_from_if}} & LP_ENC_IF)
                 | ({4{bus.stallreq_from_id}} & LP_ENC_ID)
                 | ({4{w_mc_stall}}           & LP_ENC_MC);
        w_stall       = '0;
        w_stall[3:0]  = w_req_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mc_start) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= LP_CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 6'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mc_err <= 1'b0;
        end else if (w_busy && bus.mc_start) begin
            r_mc_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (bus.clr_cnt) begin
            r_stall_cycles <= '0;
        end else if (w_stall[0] && (r_stall_cycles != LP_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mc_busy      = w_busy;
    assign bus.mc_done      = w_mc_last;
    assign bus.mc_err       = r_mc_err;
    assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall scheduler for the five-stage MIPS pipeline. It merges stall requests from the IF stage (instruction SRAM wait), from the ID stage (load-use bubble) and from the EX stage's multi-cycle unit, then drives the shared `StallBus` consumed by the PC, IF, ID, EX, MEM and WB pipeline registers. It owns the occupancy sequencer for the multi-cycle unit (divider), holding the front of the pipe for exactly `MC_LAT` cycles per operation. It also keeps a saturating stall-cycle performance counter.

## Interface
- `STALL_W`, 6: stall bus width; bit i freezes stage i (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB); 1 = Stop.
- `MC_LAT`, 33: multi-cycle op occupancy in cycles; legal range 2..63.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `stallreq_from_if`  in  1  level; instruction SRAM not ready.
- `stallreq_from_id`  in  1  level; load-use hazard detected in ID.
- `mc_start`  in  1  pulse; EX issues a multi-cycle op this cycle.
- `flush`  in  1  pulse; abort any in-flight multi-cycle op.
- `clr_cnt`  in  1  pulse; clear the performance counter.
- `stall`  out  STALL_W  stall bus to all pipeline registers.
- `mc_busy`  out  1  multi-cycle sequencer occupied (registered state == BUSY).
- `mc_done`  out  1  one-cycle pulse in the last occupancy cycle.
- `mc_err`  out  1  sticky; `mc_start` was seen while BUSY.
- `stall_cycles`  out  32  saturating count of cycles with `stall[0]`=1.

## Operation
- Request encodings, OR-combined into `stall`:
  - IF request → 6'b000011.
  - ID request → 6'b000111.
  - Multi-cycle (start accepted, or BUSY) → 6'b001111.
- Bits 4 and 5 are never asserted by this block. They are tied 0.
- Sequencer has two states, IDLE and BUSY, with a 6-bit down-counter `cnt`.
- In IDLE, `mc_start`=1 and `flush`=0:
  - This is an accepted start. `stall` shows the multi-cycle encoding in the same cycle.
  - Next state is BUSY, with `cnt` ← `MC_LAT`-2.
- In BUSY, `cnt`≠0: `cnt` decrements by 1 each cycle.
- In BUSY, `cnt`=0: `mc_done`=1 this cycle (combinational from state and `cnt`). Next state is IDLE.
- `mc_start` while BUSY is ignored (no restart, count unaffected) and sets `mc_err`. `mc_err` clears only on reset.
- `flush`=1:
  - Next state is IDLE. `mc_done` is not generated for the aborted op.
  - `stall` in the flush cycle still reflects the current state.
- `flush` and `mc_start` together in IDLE: the start is rejected, and no stall is added for it.
- `stall_cycles` increments when `stall[0]`=1. It holds at 32'hFFFF_FFFF.
- `clr_cnt` has priority over increment: counter ← 0 next cycle.
- Reset (`rst`=0 at a clock edge), including mid-operation:
  - State → IDLE, `cnt` ← 0.
  - `mc_err` ← 0, `stall_cycles` ← 0.
  - Other inputs are ignored that cycle.

## Timing
- Reset values:
  - `mc_busy`=0, `mc_done`=0, `mc_err`=0, `stall_cycles`=0.
  - `stall` = 0 whenever the IF/ID requests are low.
- `stall` is combinational from the three requests and the registered state: zero-cycle latency from request to stall.
- Accepted `mc_start` in cycle T:
  - `stall[3:0]`=4'b1111 in cycles T..T+`MC_LAT`-1.
  - `mc_busy`=1 in T+1..T+`MC_LAT`-1.
  - `mc_done`=1 only in T+`MC_LAT`-1.
  - Stall is released in T+`MC_LAT` unless another request is present.
- `mc_start` in T+`MC_LAT` (back-to-back) is accepted as a new op. No gap cycle is required.
- `flush` in cycle F while BUSY: `mc_busy`=0 from F+1, and stall is released from F+1.
- ID or IF requests during BUSY do not extend or shorten the multi-cycle count.
- `stall_cycles` reflects cycle N's stall at cycle N+1.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all requests high, then release with requests low → `stall`=0, `mc_busy`=0, `mc_err`=0, `stall_cycles`=0.
- Priority merge: `stallreq_from_if`=1 and `stallreq_from_id`=1 for one cycle → `stall`=6'b000111 that cycle, 0 the next; `stall_cycles`=1.
- Divide occupancy (`MC_LAT`=33): `mc_start` pulse at cycle 10 → `stall`=6'b001111 in cycles 10..42; `mc_done` only in cycle 42; `stall`=0 in cycle 43; `stall_cycles`=33.
- Abort and errors:
  - `mc_start` at 0, `flush` at 5 → `mc_busy`=0 from cycle 6, no `mc_done`.
  - A second `mc_start` at cycle 3 of a fresh op → `mc_err`=1 (sticky), and `mc_done` still at cycle 32.
- Edge cases:
  - `MC_LAT`=2: `mc_start` at 0 → stall in cycles 0..1, `mc_done` in 1; back-to-back `mc_start` at 2 accepted.
  - `mc_start`+`flush` same cycle in IDLE → no stall.
  - Reset asserted mid-BUSY → IDLE next cycle.
- Counter saturation: force `stall_cycles` near saturation (hierarchical preload 32'hFFFF_FFFE), stall 3 cycles → holds at 32'hFFFF_FFFF; `clr_cnt` → 0 next cycle.
